// File: rtl/dac_serial_tx.sv
// Serial transmitter for the board DAC: {CMD, code} frames shifted MSB first over SYNC_N/SCLK/DIN.
// One pending word absorbs a load that arrives while a frame is in flight.
//
// state   | meaning
// IDLE    | link quiet, waiting for load or a pending word
// SHIFT   | SYNC_N low, bits shifted out, DIN updated on SCLK rising
// GAP     | SYNC_N high between frames, done on first cycle
module dac_serial_tx #(
    parameter int              DATA_W     = 12,
    parameter int              CMD_W      = 4,
    parameter logic [CMD_W-1:0] CMD       = 4'b0011,
    parameter int              CLK_DIV    = 2,
    parameter int              GAP_CYC    = 2,
    parameter int              OFFSET_BIN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] dac_data,
    input  logic              load,
    output logic              dac_sync_n,
    output logic              dac_sclk,
    output logic              dac_din,
    output logic              busy,
    output logic              done,
    output logic              dropped
);

    localparam int FRAME_W = DATA_W + CMD_W;
    localparam int BIT_W   = $clog2(FRAME_W);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [7:0]       DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0]       GAP_LOAD = 8'(GAP_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

    logic [1:0]         state_q, state_d;
    logic [7:0]         div_cnt_q, div_cnt_d;
    logic [7:0]         gap_cnt_q, gap_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic               pend_valid_q, pend_valid_d;
    logic [DATA_W-1:0]  pend_data_q, pend_data_d;
    logic               sync_n_q, sync_n_d;
    logic               sclk_q, sclk_d;
    logic               din_q, din_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dropped_q, dropped_d;
    logic [FRAME_W-1:0] frame_w;

    function automatic logic [FRAME_W-1:0] make_frame(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] code;
        code = d;
        if (OFFSET_BIN != 0) code[DATA_W-1] = ~d[DATA_W-1];
        return {CMD, code};
    endfunction

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        sync_n_d     = sync_n_q;
        sclk_d       = sclk_q;
        din_d        = din_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        dropped_d    = 1'b0;
        frame_w      = pend_valid_q ? make_frame(pend_data_q) : make_frame(dac_data);

        case (state_q)
            S_IDLE: begin
                if (pend_valid_q || load) begin
                    state_d   = S_SHIFT;
                    shreg_d   = frame_w;
                    din_d     = frame_w[FRAME_W-1];
                    sync_n_d  = 1'b0;
                    sclk_d    = 1'b1;
                    busy_d    = 1'b1;
                    div_cnt_d = DIV_LOAD;
                    bit_cnt_d = BIT_LAST;
                    // pending word goes first; a simultaneous load becomes the new pending word
                    if (pend_valid_q) begin
                        pend_valid_d = load;
                        pend_data_d  = load ? dac_data : pend_data_q;
                    end
                end
            end
            S_SHIFT: begin
                if (div_cnt_q != 8'd0) begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end else if (sclk_q) begin
                    sclk_d    = 1'b0;
                    div_cnt_d = DIV_LOAD;
                end else if (bit_cnt_q == '0) begin
                    state_d   = S_GAP;
                    sync_n_d  = 1'b1;
                    sclk_d    = 1'b1;
                    din_d     = 1'b0;
                    done_d    = 1'b1;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    shreg_d   = shreg_q << 1;
                    din_d     = shreg_q[FRAME_W-2];
                    sclk_d    = 1'b1;
                    div_cnt_d = DIV_LOAD;
                end
            end
            S_GAP: begin
                if (gap_cnt_q != 8'd0) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                sync_n_d = 1'b1;
                sclk_d   = 1'b1;
                din_d    = 1'b0;
                busy_d   = 1'b0;
            end
        endcase

        if (busy_q && load) begin
            dropped_d    = pend_valid_q;
            pend_valid_d = 1'b1;
            pend_data_d  = dac_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            sync_n_q     <= 1'b1;
            sclk_q       <= 1'b1;
            din_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            sync_n_q     <= sync_n_d;
            sclk_q       <= sclk_d;
            din_q        <= din_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            dropped_q    <= dropped_d;
        end
    end

    assign dac_sync_n = sync_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_din    = din_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign dropped    = dropped_q;

endmodule
